// File: rtl/ntt_pkg.sv
// Shared NTT constants for the PE2 write-back path (moduli and coefficient widths).
package ntt_pkg;
  localparam int Q_KYBER = 3329;
  localparam int Q_DIL   = 8380417;
  localparam int LANE_W  = 12;
  localparam int WORD_W  = 24;

  typedef enum logic {
    KD_KYBER = 1'b0,
    KD_DIL   = 1'b1
  } kd_mode_e;
endpackage

// File: rtl/canon_reduce.sv
// Single conditional subtract to canonical range: two 12-bit Kyber lanes or one 24-bit Dilithium word.
module canon_reduce
  import ntt_pkg::*;
(
  input  logic              kd_mode_i,
  input  logic [WORD_W-1:0] d_i,
  output logic [WORD_W-1:0] d_o
);
  logic [LANE_W-1:0] hi, lo, hi_r, lo_r;
  logic [WORD_W-1:0] w_r;

  always_comb begin
    hi   = d_i[WORD_W-1:LANE_W];
    lo   = d_i[LANE_W-1:0];
    hi_r = (hi >= LANE_W'(Q_KYBER)) ? hi - LANE_W'(Q_KYBER) : hi;
    lo_r = (lo >= LANE_W'(Q_KYBER)) ? lo - LANE_W'(Q_KYBER) : lo;
    w_r  = (d_i >= WORD_W'(Q_DIL)) ? d_i - WORD_W'(Q_DIL) : d_i;
    d_o  = (kd_mode_e'(kd_mode_i) == KD_DIL) ? w_r : {hi_r, lo_r};
  end
endmodule

// File: rtl/pe2_wb_fifo.sv
// PE2 result-pair write-back FIFO toward coefficient memory, with write counter and wrap pulse.
// Build option PE2_WB_CANON_EN: canonical reduction applied to data at push (DW must be 24).
module pe2_wb_fifo
  import ntt_pkg::*;
#(
  parameter int DW    = 24,
  parameter int AW    = 7,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          KD_mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr0,
  input  logic [AW-1:0] in_addr1,
  input  logic [DW-1:0] in_data3,
  input  logic [DW-1:0] in_data4,
  output logic          wr_en,
  input  logic          wr_ready,
  output logic [AW-1:0] wr_addr0,
  output logic [AW-1:0] wr_addr1,
  output logic [DW-1:0] wr_data0,
  output logic [DW-1:0] wr_data1,
  output logic [AW-1:0] wr_cnt,
  output logic          done
);
  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] mem_a0 [DEPTH];
  logic [AW-1:0] mem_a1 [DEPTH];
  logic [DW-1:0] mem_d0 [DEPTH];
  logic [DW-1:0] mem_d1 [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]   occ_q, occ_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          done_q, done_d;
  logic          full, empty, push, pop;
  logic [DW-1:0] st_d0, st_d1;

`ifdef PE2_WB_CANON_EN
  canon_reduce u_canon0 (.kd_mode_i(KD_mode), .d_i(in_data3), .d_o(st_d0));
  canon_reduce u_canon1 (.kd_mode_i(KD_mode), .d_i(in_data4), .d_o(st_d1));
`else
  assign st_d0 = in_data3;
  assign st_d1 = in_data4;
`endif

  // Flags come only from registered occupancy, so wr_ready never reaches in_ready.
  assign full     = (occ_q == (PW+1)'(DEPTH));
  assign empty    = (occ_q == '0);
  assign in_ready = !full;
  assign wr_en    = !empty;
  assign push     = in_valid && !full;
  assign pop      = wr_ready && !empty;

  assign wr_addr0 = wr_en ? mem_a0[rptr_q] : '0;
  assign wr_addr1 = wr_en ? mem_a1[rptr_q] : '0;
  assign wr_data0 = wr_en ? mem_d0[rptr_q] : '0;
  assign wr_data1 = wr_en ? mem_d1[rptr_q] : '0;
  assign wr_cnt   = wr_cnt_q;
  assign done     = done_q;

  always_comb begin
    wptr_d   = wptr_q + PW'(push);
    rptr_d   = rptr_q + PW'(pop);
    occ_d    = occ_q + (PW+1)'(push) - (PW+1)'(pop);
    wr_cnt_d = wr_cnt_q + AW'(pop);
    done_d   = pop && (wr_cnt_q == '1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      occ_q    <= '0;
      wr_cnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      occ_q    <= occ_d;
      wr_cnt_q <= wr_cnt_d;
      done_q   <= done_d;
    end
  end

  // Storage is never reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a0[wptr_q] <= in_addr0;
      mem_a1[wptr_q] <= in_addr1;
      mem_d0[wptr_q] <= st_d0;
      mem_d1[wptr_q] <= st_d1;
    end
  end
endmodule

// File: tb/tb_pe2_wb_fifo.sv
// Randomized + directed bench for pe2_wb_fifo against a queue-based reference model.
module tb_pe2_wb_fifo;
  localparam int DW = 24, AW = 7, DEPTH = 4;

  logic clk = 0, rst = 0;
  logic KD_mode = 0, in_valid = 0, wr_ready = 0;
  logic in_ready, wr_en, done;
  logic [AW-1:0] in_addr0 = '0, in_addr1 = '0, wr_addr0, wr_addr1, wr_cnt;
  logic [DW-1:0] in_data3 = '0, in_data4 = '0, wr_data0, wr_data1;

  always #5 clk = ~clk;

  pe2_wb_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .KD_mode(KD_mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr0(in_addr0), .in_addr1(in_addr1), .in_data3(in_data3), .in_data4(in_data4),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_cnt(wr_cnt), .done(done)
  );

  typedef struct {
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
  } ent_t;

  ent_t q[$];
  int   m_cnt = 0;
  bit   m_done = 0;
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] canon(input bit m, input logic [DW-1:0] d);
`ifdef PE2_WB_CANON_EN
    int hi, lo, w;
    if (m) begin
      w = int'(d);
      if (w >= 8380417) w = w - 8380417;
      return 24'(w);
    end
    hi = int'(d[23:12]);
    lo = int'(d[11:0]);
    if (hi >= 3329) hi = hi - 3329;
    if (lo >= 3329) lo = lo - 3329;
    return {12'(hi), 12'(lo)};
`else
    return m ? d : d;
`endif
  endfunction

  task automatic check_outs(input string tag);
    ent_t h;
    chk({tag, ".in_ready"}, in_ready, q.size() < DEPTH);
    chk({tag, ".wr_en"}, wr_en, q.size() > 0);
    if (q.size() > 0) h = q[0];
    else begin h.a0 = '0; h.a1 = '0; h.d0 = '0; h.d1 = '0; end
    chk({tag, ".wr_addr0"}, wr_addr0, h.a0);
    chk({tag, ".wr_addr1"}, wr_addr1, h.a1);
    chk({tag, ".wr_data0"}, wr_data0, h.d0);
    chk({tag, ".wr_data1"}, wr_data1, h.d1);
    chk({tag, ".wr_cnt"}, wr_cnt, m_cnt);
    chk({tag, ".done"}, done, m_done);
  endtask

  // One clock: called at negedge, drives inputs, checks, advances model at posedge.
  task automatic cyc(input string tag, input bit v, input bit m, input logic [AW-1:0] a0,
                     input logic [AW-1:0] a1, input logic [DW-1:0] d3, input logic [DW-1:0] d4,
                     input bit rdy, output bit pushed, output bit popped);
    ent_t e;
    in_valid = v; KD_mode = m; in_addr0 = a0; in_addr1 = a1;
    in_data3 = d3; in_data4 = d4; wr_ready = rdy;
    #1;
    check_outs(tag);
    pushed = v && (q.size() < DEPTH);
    popped = rdy && (q.size() > 0);
    e.a0 = a0; e.a1 = a1; e.d0 = canon(m, d3); e.d1 = canon(m, d4);
    @(posedge clk);
    m_done = popped && (m_cnt == 127);
    if (popped) begin
      void'(q.pop_front());
      m_cnt = (m_cnt + 1) % 128;
    end
    if (pushed) q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst = 1;
    #1;
    chk({tag, ".in_ready"}, in_ready, 1);
    chk({tag, ".wr_en"}, wr_en, 0);
    chk({tag, ".wr_cnt"}, wr_cnt, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".wr_data0"}, wr_data0, 0);
    q.delete(); m_cnt = 0; m_done = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic idle(input string tag, input bit rdy, input int n);
    bit p, o;
    for (int i = 0; i < n; i++) cyc(tag, 0, 0, '0, '0, '0, '0, rdy, p, o);
  endtask

  initial begin
    bit p, o;
    int k, ndone;
    logic [DW-1:0] rd;
    @(negedge clk);
    do_reset("rst0");

    // Single push, popped the cycle it appears.
    cyc("one.push", 1, 0, 7'd5, 7'd69, 24'h123456, 24'h000001, 1, p, o);
    chk("one.head_d0", wr_data0, 24'h123456);
    cyc("one.pop", 0, 0, '0, '0, '0, '0, 1, p, o);
    chk("one.cnt", wr_cnt, 1);

    // Back-pressure: 5 pairs, 5th waits until space frees.
    k = 0;
    while (k < 5) begin
      cyc("bp.fill", 1, 0, 7'(10 + k), 7'(20 + k), 24'(100 + k), 24'(200 + k), 0, p, o);
      if (p) k++;
      if (k == 4) begin
        chk("bp.full_ready", in_ready, 0);
        cyc("bp.held", 1, 0, 7'd14, 7'd24, 24'd104, 24'd204, 0, p, o);
        chk("bp.held_not_taken", p, 0);
        cyc("bp.drain1", 1, 0, 7'd14, 7'd24, 24'd104, 24'd204, 1, p, o);
        if (p) k++;
      end
    end
    idle("bp.drain", 1, 6);

    // Canonical reduction and KD_mode taking effect only on later pushes.
    do_reset("rst1");
    cyc("can.k", 1, 0, 7'd1, 7'd2, 24'hD02D00, 24'h000000, 0, p, o);
    cyc("can.d", 1, 1, 7'd3, 7'd4, 24'h000000, 24'd8380420, 0, p, o);
`ifdef PE2_WB_CANON_EN
    chk("can.kyber", wr_data0, 24'h001D00);
`else
    chk("can.kyber", wr_data0, 24'hD02D00);
`endif
    cyc("can.pop", 0, 0, '0, '0, '0, '0, 1, p, o);
`ifdef PE2_WB_CANON_EN
    chk("can.dil", wr_data1, 24'd3);
`else
    chk("can.dil", wr_data1, 24'd8380420);
`endif
    idle("can.drain", 1, 2);

    // 128 pops: exactly one done pulse, right after the wrapping pop.
    do_reset("rst2");
    ndone = 0;
    for (int i = 0; i < 129; i++) begin
      cyc("wrap", 1, 0, 7'(i), 7'(i + 1), 24'(i * 3), 24'(i * 5), 1, p, o);
      if (done) ndone++;
    end
    chk("wrap.done_now", done, 1);
    chk("wrap.cnt0", wr_cnt, 0);
    in_valid = 0;
    cyc("wrap.after", 0, 0, '0, '0, '0, '0, 0, p, o);
    if (done) ndone++;
    chk("wrap.pulses", ndone, 1);

    // Reset with 3 entries queued; nothing stale afterwards.
    do_reset("rst3");
    for (int i = 0; i < 3; i++) cyc("rq.fill", 1, 0, 7'(40 + i), 7'(50 + i), 24'(i), 24'(i), 0, p, o);
    do_reset("rst_mid");
    idle("rq.after", 1, 4);

    // Steady occupancy 2 with simultaneous push/pop.
    for (int i = 0; i < 2; i++) cyc("oc.fill", 1, 0, 7'(i), 7'(i), 24'(i), 24'(i), 0, p, o);
    for (int i = 0; i < 20; i++) begin
      cyc("oc.run", 1, i[0], 7'(60 + i), 7'(70 + i), 24'($urandom), 24'($urandom), 1, p, o);
      chk("oc.both", {p, o}, 2'b11);
    end
    idle("oc.drain", 1, 3);

    // Random traffic, mode toggling.
    for (int i = 0; i < 500; i++) begin
      rd = 24'($urandom);
      cyc("rnd", ($urandom % 4) != 0, $urandom % 2, 7'($urandom), 7'($urandom),
          rd, 24'($urandom), ($urandom % 3) != 0, p, o);
      if (i == 250) do_reset("rst_rnd");
    end
    idle("rnd.drain", 1, 6);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
